// File: rtl/debounce_ctrl.sv
// Multi-channel switch debouncer: two-flop synchronizers, one shared sample-tick
// prescaler used as a clock enable, and a per-channel qualify FSM with press/release pulses.
module debounce_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int TICK_DIV     = 100_000,
  parameter int TICK_W       = 17,
  parameter int STABLE_TICKS = 10,
  parameter int STB_W        = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [NUM_CH-1:0]     i_sw,
  output logic                  o_tick,
  output logic [NUM_CH-1:0]     o_level,
  output logic [NUM_CH-1:0]     o_press,
  output logic [NUM_CH-1:0]     o_release,
  output logic [2*NUM_CH-1:0]   o_state
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [STB_W-1:0]  STB_MAX  = STB_W'(STABLE_TICKS - 1);
  localparam logic [STB_W-1:0]  STB_ONE  = STB_W'(1);

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] s;
  logic [TICK_W-1:0] cnt;

  state_t           state    [NUM_CH];
  state_t           state_nx [NUM_CH];
  logic [STB_W-1:0] scnt     [NUM_CH];
  logic [STB_W-1:0] scnt_nx  [NUM_CH];
  logic [NUM_CH-1:0] level_nx;
  logic [NUM_CH-1:0] press_nx;
  logic [NUM_CH-1:0] release_nx;

  // Synchronizer keeps running while disabled so s is fresh on re-enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= i_sw;
      s     <= sync1;
    end
  end

  assign o_tick = i_en && (cnt == TICK_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (!i_en || o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      state_nx[k]   = state[k];
      scnt_nx[k]    = scnt[k];
      press_nx[k]   = 1'b0;
      release_nx[k] = 1'b0;
      if (o_tick) begin
        unique case (state[k])
          RELEASED: begin
            if (s[k]) begin
              state_nx[k] = PRESS_CHK;
              scnt_nx[k]  = STB_ONE;
            end
          end
          PRESS_CHK: begin
            if (!s[k]) begin
              state_nx[k] = RELEASED;
              scnt_nx[k]  = '0;
            end else if (scnt[k] == STB_MAX) begin
              state_nx[k] = PRESSED;
              scnt_nx[k]  = '0;
              press_nx[k] = 1'b1;
            end else begin
              scnt_nx[k] = scnt[k] + STB_ONE;
            end
          end
          PRESSED: begin
            if (!s[k]) begin
              state_nx[k] = RELEASE_CHK;
              scnt_nx[k]  = STB_ONE;
            end
          end
          RELEASE_CHK: begin
            if (s[k]) begin
              state_nx[k] = PRESSED;
              scnt_nx[k]  = '0;
            end else if (scnt[k] == STB_MAX) begin
              state_nx[k]   = RELEASED;
              scnt_nx[k]    = '0;
              release_nx[k] = 1'b1;
            end else begin
              scnt_nx[k] = scnt[k] + STB_ONE;
            end
          end
        endcase
      end
      // Level is high while the last qualified state is pressed, including its CHK.
      level_nx[k] = (state_nx[k] == PRESSED) || (state_nx[k] == RELEASE_CHK);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state[k] <= RELEASED;
        scnt[k]  <= '0;
      end
      o_level   <= '0;
      o_press   <= '0;
      o_release <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state[k] <= state_nx[k];
        scnt[k]  <= scnt_nx[k];
      end
      o_level   <= level_nx;
      o_press   <= press_nx;
      o_release <= release_nx;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_state_dbg
    assign o_state[2*g +: 2] = state[g];
  end

endmodule

// File: doc/debounce_ctrl.md
# debounce_ctrl

Multi-channel switch debounce controller for the board's push-buttons and slide switches. It runs one shared sample-tick prescaler from the 100 MHz system clock as a clock-enable, not a derived clock. A per-channel state machine qualifies each synchronized switch input against that tick. It produces clean levels plus single-cycle press/release pulses for downstream logic in the `i_clk` domain.

## Interface
- `NUM_CH`, default 4: number of switch channels, 1..16.
- `TICK_DIV`, default 100_000: `i_clk` cycles per sample tick (1 ms at 100 MHz), 2..2^TICK_W.
- `TICK_W`, default 17: prescaler counter width.
- `STABLE_TICKS`, default 10: consecutive agreeing samples required to change state, 2..2^STB_W-1.
- `STB_W`, default 4: stability counter width.
- `i_clk`, input, 1: system clock, 100 MHz.
- `i_rst_n`, input, 1: reset, asynchronous, active-low; one clock (`i_clk`).
- `i_en`, input, 1: tick enable; low freezes debounce evaluation.
- `i_sw`, input, NUM_CH: raw switch inputs, asynchronous, bouncing.
- `o_tick`, output, 1: sample tick strobe, one cycle wide.
- `o_level`, output, NUM_CH: debounced switch level per channel.
- `o_press`, output, NUM_CH: one-cycle pulse on a qualified 0→1 transition.
- `o_release`, output, NUM_CH: one-cycle pulse on a qualified 1→0 transition.

## Operation
- **Synchronizer.** Two flops per channel, always running regardless of `i_en`. `s[k]` is the second-stage output.
- **Prescaler.** `cnt` increments each cycle while `i_en`=1.
  - `o_tick = i_en && (cnt == TICK_DIV-1)`.
  - On that edge `cnt` wraps to 0.
  - `i_en`=0: `cnt` clears to 0 and `o_tick`=0.
- **Per-channel FSM.** States RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK, with a stability counter `scnt` of STB_W bits. Transitions evaluate only on edges where `o_tick`=1; otherwise state and `scnt` hold.
  - RELEASED: `s`=1 → PRESS_CHK, `scnt`=1; otherwise stay.
  - PRESS_CHK:
    - `s`=0 → RELEASED, `scnt`=0.
    - Else if `scnt`==STABLE_TICKS-1 → PRESSED, `scnt`=0, fire `o_press`.
    - Else `scnt`+1.
  - PRESSED: `s`=0 → RELEASE_CHK, `scnt`=1; otherwise stay.
  - RELEASE_CHK:
    - `s`=1 → PRESSED, `scnt`=0.
    - Else if `scnt`==STABLE_TICKS-1 → RELEASED, `scnt`=0, fire `o_release`.
    - Else `scnt`+1.
- **Outputs.**
  - `o_level[k]`=1 in PRESSED and RELEASE_CHK, 0 otherwise; registered from state.
  - `o_press` and `o_release` are registered and high exactly one cycle.
- **Boundary conditions.**
  - Channels are fully independent; multiple channels may pulse in the same cycle.
  - A glitch shorter than one tick period between samples is invisible.
  - A sample disagreeing inside a CHK state aborts to the prior stable state with no pulse.
  - `scnt` never exceeds STABLE_TICKS-1 and never wraps.
  - `i_en` deasserted mid-CHK: `scnt` and state hold; evaluation resumes with the first tick after re-enable, a full TICK_DIV enabled cycles later.
  - Reset at any time clears everything: all flops, `cnt`, `scnt`=0, all FSMs to RELEASED, all outputs 0, no pulse emitted.

## Timing
- Reset values: `o_tick`=0, `o_level`=0, `o_press`=0, `o_release`=0.
- First `o_tick` occurs in the TICK_DIV-th cycle with `i_en`=1 after reset release. Ticks then repeat every TICK_DIV cycles.
- Synchronizer latency is 2 cycles: `i_sw` change to `s`.
- Press pulse timing:
  - `o_press[k]` and the `o_level[k]` rise appear in the cycle after the tick edge that samples the STABLE_TICKS-th consecutive `s`=1.
  - Release is symmetric for `o_release[k]` and the `o_level[k]` fall.
- Worst-case latency from a clean edge is 2 + STABLE_TICKS×TICK_DIV + 1 cycles.

## Test plan
Parameters for all scenarios: NUM_CH=2, TICK_DIV=4, STABLE_TICKS=3.
- **Reset and tick cadence.** Hold `i_rst_n`=0 with `i_sw`=2'b11, then release with `i_en`=1 → all outputs 0 during reset. `o_tick` is high on enabled cycles 4, 8, 12, and only those.
- **Clean press.** Set `i_sw[0]`=1 and hold → `o_press[0]` pulses once, one cycle after the 3rd tick sampling `s`=1. `o_level[0]` goes 1 and stays 1. Channel 1 stays 0 throughout.
- **Bounce rejection.** `s[0]`=1 for 2 ticks, then 0 at the 3rd tick → no `o_press`, `o_level[0]`=0. Next, hold high for 3 ticks → exactly one `o_press[0]`.
- **Release and simultaneity.** Press both channels on the same cycle → `o_press`=2'b11 in one cycle. Release both → `o_release`=2'b11 one cycle after the 3rd low tick, and `o_level`=0.
- **Enable freeze.** In PRESS_CHK with `scnt`=2, drop `i_en` for 20 cycles → no tick and no pulse. Re-enable with `s`=1 → `o_press` one cycle after the next tick, 4 enabled cycles later.
- **Reset mid-operation.** While PRESSED, pulse `i_rst_n` low asynchronously mid-cycle → `o_level` clears immediately and no `o_release` fires. After release, re-qualification needs 3 fresh ticks.
